// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key expansion into an 11-entry round-key store, one round key per clock.
// Keys are read back by index with one cycle of latency for the iterative round datapath.
module aes_key_sched_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key,
    output logic         sched_done,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Forward S-box, byte n at bits 8n..8n+7.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [0:127]   slot_q [0:NR];
    logic [0:127]   rd_key_q, rd_key_d;
    logic           accept;
    logic           rnd_ok;
    logic [0:127]   prev;
    logic [0:127]   key_next;
    logic [7:0]     rcon;
    logic [0:31]    rot, sub, t, n0, n1, n2, n3;

    assign rnd_ok = (rnd_q >= 4'd1) && (rnd_q <= 4'(NR));

    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Single shared round function: previous slot selected by rnd, four S-boxes.
    always_comb begin
        prev = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (rnd_q == 4'(i + 1)) prev = slot_q[i];
        end
        rot      = {prev[104:127], prev[96:103]};
        sub      = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
        t        = sub ^ {rcon, 24'h000000};
        n0       = prev[0:31]   ^ t;
        n1       = prev[32:63]  ^ n0;
        n2       = prev[64:95]  ^ n1;
        n3       = prev[96:127] ^ n2;
        key_next = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    accept  = 1'b1;
                    state_d = EXPAND;
                    rnd_d   = 4'd1;
                end
            end
            EXPAND: begin
                if (!rnd_ok) begin
                    state_d = IDLE;
                end else if (rnd_q == 4'(NR)) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_key_d = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (rd_idx == 4'(i)) rd_key_d = slot_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rnd_q    <= '0;
            rd_key_q <= '0;
            for (int unsigned i = 0; i <= NR; i++) slot_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            rd_key_q <= rd_key_d;
            if (accept) slot_q[0] <= key_in;
            if (state_q == EXPAND && rnd_ok) begin
                for (int unsigned i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) slot_q[i] <= key_next;
                end
            end
        end
    end

    assign key_ready  = (state_q == IDLE) || (state_q == DONE);
    assign busy       = (state_q == EXPAND);
    assign sched_done = (state_q == DONE);
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: FIPS-197 vectors plus random keys checked against a word-level model.
module tb_aes_key_sched_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         sched_done;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] ref_rk [0:10];
    logic [127:0] exp_q [$];
    int           idx_q [$];
    logic         rd_req = 1'b0;
    logic         rd_vld = 1'b0;

    aes_key_sched_seq #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .sched_done (sched_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine transform.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic issue_read(input logic [3:0] idx, input logic [127:0] exp);
        rd_idx = idx;
        rd_req = 1'b1;
        exp_q.push_back(exp);
        idx_q.push_back(int'(idx));
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected got=%h want=none", rd_key);
            end else begin
                chk($sformatf("rd_key[%0d]", idx_q.pop_front()), rd_key, exp_q.pop_front());
            end
        end
    end

    // Accept k, optionally keep key_valid high with a different key, and time sched_done.
    task automatic load_key(input logic [127:0] k, input logic hold, input logic [127:0] other);
        chk("key_ready_pre", 128'(key_ready), 128'(1));
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        chk("sched_done_after_accept", 128'(sched_done), 128'(0));
        chk("busy_after_accept", 128'(busy), 128'(1));
        if (hold) key_in = other;
        else      key_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c < 10) begin
                chk($sformatf("expand_c%0d_flags", c), {125'd0, key_ready, busy, sched_done}, 128'b010);
            end else begin
                chk("done_flags", {125'd0, key_ready, busy, sched_done}, 128'b101);
                key_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        int           idx;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rd_idx    = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_sched_done", 128'(sched_done), 128'(0));
        chk("rst_rd_key", rd_key, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 A.1 key, with a competing key held on the input during EXPAND.
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        load_key(k, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        issue_read(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        issue_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue_read(4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        model_expand(k);
        for (int i = 10; i >= 0; i--) issue_read(4'(i), ref_rk[i]);

        // Zero key accepted straight from DONE.
        load_key(128'd0, 1'b0, 128'd0);
        issue_read(4'd1, 128'h62636363626363636263636362636363);
        issue_read(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        issue_read(4'd12, 128'd0);

        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            load_key(k, n[0], {$urandom, $urandom, $urandom, $urandom});
            model_expand(k);
            for (int j = 0; j < 12; j++) begin
                idx = int'($urandom_range(0, 15));
                issue_read(4'(idx), (idx <= 10) ? ref_rk[idx] : 128'd0);
            end
        end

        // Asynchronous reset in the middle of an expansion.
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_key_ready", 128'(key_ready), 128'(1));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_sched_done", 128'(sched_done), 128'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) issue_read(4'(i), 128'd0);
        chk("post_rst_sched_done", 128'(sched_done), 128'(0));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Sequential AES-128 key schedule with an on-chip round-key store. Accepts a 128-bit cipher key over a valid/ready handshake and expands it one round key per clock into an 11-entry register file (key0..key10). It then serves keys by index to the iterative round datapath: ascending index for encryption, descending for decryption. It replaces the fully unrolled combinational expansion chain where area matters more than key-load latency.

## Interface
- NR, 10, number of round keys generated after key0; only 10 is supported (AES-128).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_in  in  [0:127]  cipher key; byte 0 at bits 0:7, column-major (word0 = bits 0:31).
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  block can accept a key (IDLE or DONE).
- rd_idx  in  [3:0]  round-key index to read, 0..10.
- rd_key  out  [0:127]  registered round key for rd_idx, same bit ordering as key_in.
- sched_done  out  1  all 11 slots hold the expansion of the last accepted key.
- busy  out  1  expansion in progress.

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset state: IDLE.
- IDLE: key_ready=1, busy=0, sched_done=0.
- Accept condition: key_valid && key_ready at a rising edge. On accept, slot[0] <= key_in, rnd <= 1, state <= EXPAND.
- EXPAND: key_ready=0, busy=1. Each cycle slot[rnd] <= F(slot[rnd-1], rcon[rnd]); rnd <= rnd+1. After slot[10] is written, state <= DONE.
- F (FIPS-197):
  - t = SubWord(RotWord(w3)) ^ rcon.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord moves byte 0 to position 3. SubWord is the forward S-box applied per byte.
- rcon[1..10] top byte: 01,02,04,08,10,20,40,80,1B,36; low 24 bits are zero. rcon comes from a case on rnd, not from GF doubling.
- rnd is a 4-bit counter, 1..10. It never wraps in operation; any value outside 1..10 in EXPAND forces IDLE.
- DONE: sched_done=1, key_ready=1, busy=0. A new accepted key restarts the sequence: slot[0] is overwritten, sched_done drops on the same edge, and state goes to EXPAND.
- key_valid during EXPAND is ignored (key_ready=0). No queueing; the upstream source must hold the key.
- Read port: rd_key <= slot[rd_idx] every cycle. rd_idx 11..15 gives rd_key <= 0.
- Reads during EXPAND are legal but return stale data for unwritten slots. Consumers gate on sched_done.
- Reset: asynchronous, any state, including mid-EXPAND. All slots, rd_key and rnd go to 0, state goes to IDLE, and the partial schedule is discarded.
- Reset values: key_ready=1, sched_done=0, busy=0, rd_key=0.

## Timing
- Accept at edge E0. slot[k] is written at edge E0+k. slot[10] and sched_done=1 are visible after edge E0+10.
- Key-load latency is 10 cycles from acceptance to sched_done. Back-to-back keys: one accepted every 11 cycles minimum (accept in DONE).
- Read latency: 1 cycle. rd_idx presented before edge N appears on rd_key after edge N, so an index can change every cycle.
- key_ready, sched_done and busy are decoded from the state register (glitch-free, no combinational path from key_valid).
- Critical path: one S-box plus a 4-deep XOR chain per cycle. The four S-boxes are shared across all rounds.

## Test plan
- FIPS-197 A.1 load: accept key 2b7e151628aed2a6abf7158809cf4f3c.
  - sched_done rises exactly 10 cycles after accept.
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 -> the key itself.
- Zero key:
  - rd_idx=1 -> 62636363626363636263636362636363.
  - rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
  - rd_idx=12 -> all zero.
- Handshake:
  - Hold key_valid high with a different key throughout EXPAND -> key_ready=0 and the key is ignored; schedule matches the first key.
  - In DONE, the second key is accepted: sched_done drops next cycle and returns 10 cycles later with the new schedule.
- Reset mid-operation: assert rst_n low at cycle 5 of EXPAND -> immediately state IDLE, key_ready=1, busy=0, sched_done=0. After release, rd_key reads 0 for every index.
- Descending read sweep: after sched_done, drive rd_idx 10 down to 0 on consecutive cycles -> rd_key matches the reference schedule, each one cycle later, with no bubbles.
